// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: state encoding, frame
// geometry and the odd-parity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // A frame is good when the data bits plus the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with first-word fall-through head; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // Extra pointer bit tells full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the raw lines,
// deserializes 11-bit frames and queues good bytes onto a valid/ready stream.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 96000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kb_data,
  output logic       kb_valid,
  input  logic       kb_ready,
  output logic       frame_err,
  output logic       ovf
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fclk;
  logic [FW-1:0] fcnt;
  logic          flip;
  logic          sample;
  logic          bit_in;

  ps2_state_e    state, state_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          err_now;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    head;

  // fclk flips only after the synchronized clock disagreed for FILTER_LEN cycles in a row.
  assign flip   = (clk_sync[1] != fclk) && (fcnt == FW'(FILTER_LEN - 1));
  assign sample = flip && fclk;
  assign bit_in = dat_sync[1];

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      fclk     <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (flip) begin
        fclk <= clk_sync[1];
        fcnt <= '0;
      end else if (clk_sync[1] != fclk) begin
        fcnt <= fcnt + FW'(1);
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Saturating idle-time counter; a frame stalled mid-way is abandoned when it tops out.
  assign timeout = (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES)) && !sample;

  always_ff @(posedge clk48) begin
    if (!rst_n || sample || state == S_IDLE) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    err_now   = 1'b0;
    push_req  = 1'b0;
    if (timeout) begin
      state_nxt = S_IDLE;
      err_now   = 1'b1;
    end else if (sample) begin
      case (state)
        S_IDLE: begin
          if (!bit_in) begin
            state_nxt = S_DATA;
            bit_nxt   = 3'd0;
          end else begin
            err_now = 1'b1;
          end
        end
        S_DATA: begin
          sh_nxt  = {bit_in, shreg[7:1]};
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_nxt   = bit_in;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (bit_in && odd_parity_ok(shreg, par_bit)) push_req = 1'b1;
          else                                         err_now  = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= sh_nxt;
      par_bit   <= par_nxt;
      frame_err <= err_now;
      ovf       <= push_req && full && !pop;
    end
  end

  // Stream: kb_valid && kb_ready pops at the clock edge; while kb_valid is high
  // and kb_ready low the head (kb_data) and kb_valid hold.
  assign pop      = kb_valid && kb_ready;
  assign kb_valid = !empty;
  assign kb_data  = kb_valid ? head : 8'h00;

  byte_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk48),
    .rst_n(rst_n),
    .push (push_req),
    .din  (shreg),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver. Samples the raw, asynchronous PS/2 clock and data lines, deserializes 11-bit device-to-host frames, and checks start, odd-parity and stop bits. Good scan-code bytes go through a small FIFO into the valid/ready byte stream (`kb_data`/`kb_valid`/`kb_ready`) that `core` consumes. It is the producing end of that stream and is receive-only: it never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, 8: consecutive stable `clk48` cycles required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 96000: cycles without a sample event, in any non-IDLE state, before the frame is aborted (2 ms at 48 MHz).
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥2.
- `clk48`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `kb_data`  out  8  scan-code byte at the FIFO head.
- `kb_valid`  out  1  FIFO not empty.
- `kb_ready`  in  1  consumer accepts `kb_data` this cycle.
- `frame_err`  out  1  one-cycle pulse: frame discarded (start, parity, stop or timeout error).
- `ovf`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- Input conditioning:
  - Both raw lines pass through 2-FF synchronizers.
  - A filter register `fclk` (reset 1) takes the synchronized clock level only after it has differed from `fclk` for `FILTER_LEN` consecutive cycles.
  - A sample event is the cycle in which `fclk` goes 1→0. The synchronized data is captured in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Reset state is IDLE.
  - IDLE: on a sample event, data=0 → DATA with bit count 0. Data=1 → stay in IDLE and pulse `frame_err`.
  - DATA: shift LSB-first (new bit into bit 7 of the shift register). After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: on the sample event:
    - If stop=1 and the XOR of 8 data bits plus the parity bit equals 1, push the byte.
    - Otherwise pulse `frame_err` and discard.
    - Always return to IDLE.
- Timeout: the counter clears on every sample event and while in IDLE. It reaching `TIMEOUT_CYCLES` in a non-IDLE state forces IDLE, pulses `frame_err` and discards the partial byte.
- FIFO push:
  - Accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the byte is dropped and `ovf` pulses.
- FIFO pop: occurs when `kb_valid && kb_ready`.
- Stream rules:
  - `kb_data` and `kb_valid` are stable while `kb_valid && !kb_ready`.
  - `kb_data` is don't-care when `kb_valid=0`.
  - Bytes are delivered in arrival order, with no duplication.
- Push and pop in the same cycle on a non-empty FIFO: count unchanged, both take effect.
- Reset values: `kb_data`=0, `kb_valid`=0, `frame_err`=0, `ovf`=0. FIFO empty, all counters 0, `fclk`=1.
- Reset mid-frame: the partial frame and FIFO contents are lost. Any stray trailing bits are resolved by the start check or the timeout.

## Timing
- Raw `ps2_clk` falling edge → sample event: 2 (synchronizer) + `FILTER_LEN` + 1 cycles.
- Stop-bit sample event in cycle N → FIFO write at the end of N → `kb_valid`=1 in cycle N+1.
- `frame_err` and `ovf` are asserted in cycle N+1 for exactly one cycle.
- Pop takes effect at the clock edge where `kb_valid && kb_ready`. The next head byte, if any, is presented in the following cycle with `kb_valid` staying high (full throughput, one byte per cycle).
- PS/2 bit period (60–100 µs) is far above filter and pipeline delay. Successive frames need no idle gap beyond the protocol's own.

## Structure
- `ps2_pkg`: FSM state encoding, the frame bit counts (8 data, 11 total), and the odd-parity rule as a function.
- Sub-module `byte_fifo`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push, pop, full, empty, head.
  - Pointer width `$clog2(DEPTH)+1` for the full/empty distinction.
  - Reused by other stream producers.
- Top level holds the synchronizers, filter, FSM, timeout counter and error pulses.

## Test plan
- Frame 0x1C (start 0, data, parity 0, stop 1), `kb_ready`=1 → exactly one `kb_valid` cycle with `kb_data`=0x1C, `frame_err` never asserted.
- Frame 0x1C with parity 1 → no `kb_valid`, `frame_err` high for one cycle at N+1. The next good frame 0x5A is received correctly.
- `kb_ready`=0, frames 0xF0, 0x1C, 0xE0, 0x74, 0x5A → `kb_valid` held with 0xF0 stable, `ovf` pulses once on 0x5A. Then `kb_ready`=1 drains F0, 1C, E0, 74 on four consecutive cycles and `kb_valid` drops.
- 3-cycle low glitch on `ps2_clk` in IDLE (`FILTER_LEN`=8) → no sample event, FSM stays IDLE, no pulses. A 10-cycle low pulse with data=0 does enter DATA.
- Start plus 4 data bits, then lines idle high → `frame_err` pulse `TIMEOUT_CYCLES` after the last sample event. A following full frame 0x29 is delivered intact.
- `rst_n`=0 for 1 cycle during bit 5 of a frame, with one byte queued → the queued byte is lost and all outputs are 0 next cycle. The tail bits cause a `frame_err` pulse via the start check or the timeout, then 0x1C is received correctly.
